// File: rtl/mem_stage_arbiter.sv
// rtl/mem_stage_arbiter.sv - MEM-stage data port arbiter between the CPU pipeline and an external requester
// CPU traffic passes through combinationally; X accesses are latched and sequenced, with a CPU-streak cap to avoid starving X.
module mem_stage_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int READ_LAT = 1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_m_req,
   input  logic        i_m_we,
   input  logic [31:0] i_m_addr,
   input  logic [31:0] i_m_wdata,
   output logic [31:0] o_m_rdata,
   output logic        o_m_stall,
   input  logic        i_x_req,
   input  logic        i_x_we,
   input  logic [31:0] i_x_addr,
   input  logic [31:0] i_x_wdata,
   output logic        o_x_ack,
   output logic [31:0] o_x_rdata,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_X_ACC = 2'd1;
   localparam logic [1:0] S_X_ACK = 2'd2;

   logic [1:0]  r_state;
   logic [3:0]  r_streak;
   logic [1:0]  r_cnt;
   logic        r_x_we;
   logic [31:0] r_x_addr;
   logic [31:0] r_x_wdata;
   logic [31:0] r_x_rdata;
   logic        r_x_ack;

   logic w_streak_full;
   logic w_grant_x;
   logic w_read_done;

   assign w_streak_full = (r_streak == 4'(MAX_WAIT));
   assign w_grant_x     = (r_state == S_IDLE) && i_x_req && (!i_m_req || w_streak_full);
   assign w_read_done   = (r_cnt == 2'(READ_LAT - 1));

   assign o_m_rdata = i_mem_rdata;
   assign o_x_ack   = r_x_ack;
   assign o_x_rdata = r_x_rdata;

   // The grant cycle already presents X's address but never writes; the store happens in X_ACC.
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = i_m_addr;
      o_mem_wdata = i_m_wdata;
      o_m_stall   = 1'b0;
      if (r_state == S_X_ACC) begin
         o_mem_we    = r_x_we;
         o_mem_addr  = r_x_addr;
         o_mem_wdata = r_x_wdata;
         o_m_stall   = i_m_req;
      end else if (w_grant_x) begin
         o_mem_addr  = i_x_addr;
         o_mem_wdata = i_x_wdata;
         o_m_stall   = i_m_req;
      end else begin
         o_mem_we = i_m_req & i_m_we;
      end
      if (i_reset) begin
         o_mem_we  = 1'b0;
         o_m_stall = 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_streak  <= 4'd0;
         r_cnt     <= 2'd0;
         r_x_we    <= 1'b0;
         r_x_addr  <= 32'd0;
         r_x_wdata <= 32'd0;
         r_x_rdata <= 32'd0;
         r_x_ack   <= 1'b0;
      end else begin
         r_x_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_x) begin
                  r_x_we    <= i_x_we;
                  r_x_addr  <= i_x_addr;
                  r_x_wdata <= i_x_wdata;
                  r_cnt     <= 2'd0;
                  r_streak  <= 4'd0;
                  r_state   <= S_X_ACC;
               end else if (i_m_req && i_x_req) begin
                  if (!w_streak_full) r_streak <= r_streak + 4'd1;
               end else begin
                  r_streak <= 4'd0;
               end
            end
            S_X_ACC: begin
               if (r_x_we) begin
                  r_x_ack <= 1'b1;
                  r_state <= S_X_ACK;
               end else if (w_read_done) begin
                  r_x_rdata <= i_mem_rdata;
                  r_x_ack   <= 1'b1;
                  r_state   <= S_X_ACK;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_X_ACK: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_arbiter.sv
// tb/tb_mem_stage_arbiter.sv - self-checking bench for mem_stage_arbiter
// Transaction-level reference model compared every cycle, plus directed literal checks.
module tb_mem_stage_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int READ_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_req = 1'b0, m_we = 1'b0, x_req = 1'b0, x_we = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, x_addr = '0, x_wdata = '0;
   logic [31:0] m_rdata, x_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        m_stall, x_ack, mem_we;

   int errors = 0;
   int checks = 0;

   logic [31:0] ram [0:255] = '{8: 32'hDEADBEEF, default: 32'h0};
   logic        pw;
   logic [7:0]  pa;
   logic [31:0] pd;

   always #5 clk = ~clk;

   mem_stage_arbiter #(.MAX_WAIT(MAX_WAIT), .READ_LAT(READ_LAT)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
      .o_m_rdata(m_rdata), .o_m_stall(m_stall),
      .i_x_req(x_req), .i_x_we(x_we), .i_x_addr(x_addr), .i_x_wdata(x_wdata),
      .o_x_ack(x_ack), .o_x_rdata(x_rdata),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   assign mem_rdata = ram[mem_addr[9:2]];

   always @(negedge clk) begin
      pw = mem_we;
      pa = mem_addr[9:2];
      pd = mem_wdata;
   end
   always @(posedge clk) if (pw) ram[pa] <= pd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an X transaction occupies the port for dur cycles after its grant,
   // then one acknowledge cycle; "since" counts cycles elapsed from the grant.
   logic [31:0] shadow [0:255] = '{8: 32'hDEADBEEF, default: 32'h0};
   bit          act = 0;
   int          since = 0;
   int          streak = 0;
   bit          lx_we = 0;
   logic [31:0] lx_addr = '0, lx_wd = '0, exp_xrd = '0;

   always @(negedge clk) begin
      int  dur;
      bit  g;
      logic        e_we, e_stall, e_ack;
      logic [31:0] e_addr, e_wd;
      dur = lx_we ? 1 : READ_LAT;
      g = 0;
      if (rst) begin
         act = 0; streak = 0; exp_xrd = '0;
         chk("mem_we", {31'd0, mem_we}, 32'd0);
         chk("m_stall", {31'd0, m_stall}, 32'd0);
         chk("x_ack", {31'd0, x_ack}, 32'd0);
         chk("x_rdata", x_rdata, 32'd0);
      end else begin
         e_ack = 0;
         e_we = m_req & m_we; e_addr = m_addr; e_wd = m_wdata; e_stall = 0;
         if (act && since >= 1 && since <= dur) begin
            e_we = lx_we && since == 1; e_addr = lx_addr; e_wd = lx_wd; e_stall = m_req;
         end else if (act && since == dur + 1) begin
            e_ack = 1;
         end else begin
            g = x_req && (!m_req || streak == MAX_WAIT);
            if (g) begin
               e_we = 0; e_addr = x_addr; e_wd = x_wdata; e_stall = m_req;
            end
         end
         chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, e_wd);
         chk("m_stall", {31'd0, m_stall}, {31'd0, e_stall});
         chk("x_ack", {31'd0, x_ack}, {31'd0, e_ack});
         chk("x_rdata", x_rdata, exp_xrd);
         if (act) begin
            if (!lx_we && since == dur) exp_xrd = shadow[lx_addr[9:2]];
            if (since == dur + 1) act = 0;
            else since++;
         end else if (g) begin
            act = 1; since = 1; streak = 0;
            lx_we = x_we; lx_addr = x_addr; lx_wd = x_wdata;
         end else begin
            streak = (m_req && x_req) ? ((streak < MAX_WAIT) ? streak + 1 : MAX_WAIT) : 0;
         end
         if (e_we) shadow[e_addr[9:2]] = e_wd;
      end
      chk("m_rdata", m_rdata, mem_rdata);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acks;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x_ack", {31'd0, x_ack}, 32'd0);
      chk("rst_x_rdata", x_rdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      rst = 1'b0;

      // CPU store then load, same-cycle
      m_req = 1; m_we = 1; m_addr = 32'h10; m_wdata = 32'hA5A5A5A5;
      #1 chk("cpu_we", {31'd0, mem_we}, 32'd1);
      chk("cpu_stall", {31'd0, m_stall}, 32'd0);
      step();
      m_we = 0;
      #1 chk("cpu_readback", m_rdata, 32'hA5A5A5A5);
      step();
      m_req = 0;

      // X write with idle CPU
      x_req = 1; x_we = 1; x_addr = 32'h84; x_wdata = 32'h1234;
      #1 chk("xw_grant_we", {31'd0, mem_we}, 32'd0);
      step();
      chk("xw_acc_we", {31'd0, mem_we}, 32'd1);
      chk("xw_acc_addr", mem_addr, 32'h84);
      step();
      chk("xw_ack", {31'd0, x_ack}, 32'd1);
      x_req = 0;
      step();
      chk("xw_ram", ram[8'h21], 32'h1234);

      // Streak: CPU wins MAX_WAIT cycles, then X
      m_req = 1; m_we = 0; m_addr = 32'h0C;
      x_req = 1; x_we = 1; x_addr = 32'h88; x_wdata = 32'h7;
      for (int i = 0; i < MAX_WAIT; i++) begin
         #1 chk("streak_cpu_addr", mem_addr, 32'h0C);
         step();
      end
      #1 chk("streak_grant_stall", {31'd0, m_stall}, 32'd1);
      step();
      chk("streak_acc_stall", {31'd0, m_stall}, 32'd1);
      step();
      chk("streak_ack", {31'd0, x_ack}, 32'd1);
      chk("streak_ack_stall", {31'd0, m_stall}, 32'd0);
      step();
      for (int i = 0; i < MAX_WAIT; i++) begin
         #1 chk("restreak_cpu", {31'd0, m_stall}, 32'd0);
         step();
      end
      #1 chk("restreak_grant", {31'd0, m_stall}, 32'd1);
      x_req = 0; m_req = 0;
      repeat (3) step();

      // X read, READ_LAT=2, then CPU store must not disturb x_rdata
      x_req = 1; x_we = 0; x_addr = 32'h20;
      step(); step(); step();
      chk("xr_ack", {31'd0, x_ack}, 32'd1);
      chk("xr_data", x_rdata, 32'hDEADBEEF);
      x_req = 0;
      step();
      m_req = 1; m_we = 1; m_addr = 32'h30; m_wdata = 32'hCAFEF00D;
      step();
      m_req = 0; m_we = 0;
      step();
      chk("xr_hold", x_rdata, 32'hDEADBEEF);
      chk("cpu_ram", ram[8'h0C], 32'hCAFEF00D);

      // x_req held across ack: one ack per transaction
      x_req = 1; x_we = 1; x_addr = 32'h90; x_wdata = 32'h11;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         #1 if (x_ack) acks++;
         step();
      end
      x_req = 0;
      chk("held_acks", acks, 32'd2);
      repeat (2) step();

      // Reset during an X write
      x_req = 1; x_we = 1; x_addr = 32'h40; x_wdata = 32'h5555;
      step();
      #1 rst = 1;
      #1 chk("rst_abort_we", {31'd0, mem_we}, 32'd0);
      x_req = 0;
      step();
      rst = 0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         #1 if (x_ack) acks++;
         step();
      end
      chk("rst_no_ack", acks, 32'd0);
      chk("rst_ram_clean", ram[8'h10], 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
